// File: rtl/vl_strip_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : vl_strip_ctrl_if
// Purpose  : Request / strip / CSR bundle between decode, vl_strip_ctrl and
//            the vector lane sequencer.
// Revision : 1.0 - initial release
// =============================================================================
interface vl_strip_ctrl_if #(
    parameter int AVL_W = 16,
    parameter int VL_W  = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [AVL_W-1:0] req_avl;
    logic [2:0]       req_vsew;
    logic [2:0]       req_vlmul;
    logic             abort;
    logic             strip_valid;
    logic             strip_ready;
    logic [VL_W-1:0]  strip_vl;
    logic [AVL_W-1:0] strip_offset;
    logic             strip_last;
    logic [VL_W-1:0]  csr_vl;
    logic [6:0]       csr_vtype;
    logic             done;

    // master: decode + lane sequencer side; slave: the strip controller
    modport master (
        output req_valid, req_avl, req_vsew, req_vlmul, abort, strip_ready,
        input  req_ready, strip_valid, strip_vl, strip_offset, strip_last,
               csr_vl, csr_vtype, done
    );

    modport slave (
        input  req_valid, req_avl, req_vsew, req_vlmul, abort, strip_ready,
        output req_ready, strip_valid, strip_vl, strip_offset, strip_last,
               csr_vl, csr_vtype, done
    );
endinterface
`default_nettype wire

// File: rtl/vl_strip_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : vl_strip_ctrl
// Purpose  : Sequential vsetvl + strip-mining controller. Validates a vector
//            configuration, registers vl/vtype and issues the AVL as strips.
//            Optional macro VL_STRIP_FRAC_LMUL_EN enables fractional LMUL.
// Revision : 1.0 - initial release
// =============================================================================
module vl_strip_ctrl #(
    parameter int VLEN  = 128,
    parameter int ELEN  = 64,
    parameter int AVL_W = 16,
    parameter int VL_W  = $clog2(VLEN) + 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    vl_strip_ctrl_if.slave bus
);
    localparam int         MW          = (AVL_W > VL_W) ? AVL_W : VL_W;
    localparam logic [6:0] c_vtype_ill = 7'b100_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [AVL_W-1:0] r_avl;
    logic [AVL_W-1:0] r_remaining;
    logic [AVL_W-1:0] r_offset;
    logic [2:0]       r_vsew;
    logic [2:0]       r_vlmul;
    logic [MW-1:0]    r_vlmax;
    logic             r_req_ready;
    logic             r_strip_valid;
    logic             r_strip_last;
    logic [VL_W-1:0]  r_strip_vl;
    logic [VL_W-1:0]  r_csr_vl;
    logic [6:0]       r_csr_vtype;
    logic             r_done;

    int               w_base;
    int               w_sew;
    int               w_vlmax_i;
    logic [MW-1:0]    w_vlmax;
    logic             w_legal;
    logic             w_fire;
    logic [AVL_W-1:0] w_rem_next;
    logic [AVL_W-1:0] w_off_next;

    function automatic logic [MW-1:0] f_min(input logic [MW-1:0] a, input logic [MW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // VLMAX and legality are evaluated on the latched request during CALC
    always_comb begin
        w_base    = VLEN >> (3 + int'(r_vsew));
        w_sew     = 8 << r_vsew;
        w_vlmax_i = 0;
        w_legal   = 1'b0;
        if ((r_vsew <= 3'd4) && (w_sew <= ELEN)) begin
            if (r_vlmul <= 3'd3) begin
                w_vlmax_i = w_base << r_vlmul;
                w_legal   = (w_vlmax_i != 0);
            end
`ifdef VL_STRIP_FRAC_LMUL_EN
            else if (r_vlmul >= 3'd5) begin
                w_vlmax_i = w_base >> (8 - int'(r_vlmul));
                w_legal   = (w_vlmax_i != 0) && ((w_sew << (8 - int'(r_vlmul))) <= ELEN);
            end
`endif
        end
        w_vlmax = MW'(w_vlmax_i);
    end

    assign w_fire     = r_strip_valid && bus.strip_ready;
    assign w_rem_next = r_remaining - AVL_W'(r_strip_vl);
    assign w_off_next = r_offset + AVL_W'(r_strip_vl);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_avl         <= '0;
            r_remaining   <= '0;
            r_offset      <= '0;
            r_vsew        <= '0;
            r_vlmul       <= '0;
            r_vlmax       <= '0;
            r_req_ready   <= 1'b1;
            r_strip_valid <= 1'b0;
            r_strip_last  <= 1'b0;
            r_strip_vl    <= '0;
            r_csr_vl      <= '0;
            r_csr_vtype   <= c_vtype_ill;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_avl       <= bus.req_avl;
                        r_vsew      <= bus.req_vsew;
                        r_vlmul     <= bus.req_vlmul;
                        r_req_ready <= 1'b0;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_vlmax <= w_vlmax;
                    if (bus.abort) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (!w_legal) begin
                        r_csr_vl    <= '0;
                        r_csr_vtype <= c_vtype_ill;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_csr_vl    <= VL_W'(f_min(MW'(r_avl), w_vlmax));
                        r_csr_vtype <= {1'b0, r_vsew, r_vlmul};
                        r_remaining <= r_avl;
                        r_offset    <= '0;
                        if (r_avl == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_strip_valid <= 1'b1;
                            r_strip_vl    <= VL_W'(f_min(MW'(r_avl), w_vlmax));
                            r_strip_last  <= (MW'(r_avl) <= w_vlmax);
                            r_state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // abort wins over a same-cycle handshake: that strip is not taken
                    if (bus.abort) begin
                        r_strip_valid <= 1'b0;
                        r_strip_vl    <= '0;
                        r_strip_last  <= 1'b0;
                        r_offset      <= '0;
                        r_req_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (w_fire) begin
                        r_remaining <= w_rem_next;
                        if (r_strip_last) begin
                            r_strip_valid <= 1'b0;
                            r_strip_vl    <= '0;
                            r_strip_last  <= 1'b0;
                            r_offset      <= '0;
                            r_done        <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_offset     <= w_off_next;
                            r_strip_vl   <= VL_W'(f_min(MW'(w_rem_next), r_vlmax));
                            r_strip_last <= (MW'(w_rem_next) <= r_vlmax);
                        end
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.strip_valid  = r_strip_valid;
    assign bus.strip_vl     = r_strip_vl;
    assign bus.strip_offset = r_offset;
    assign bus.strip_last   = r_strip_last;
    assign bus.csr_vl       = r_csr_vl;
    assign bus.csr_vtype    = r_csr_vtype;
    assign bus.done         = r_done;
endmodule
`default_nettype wire

// File: tb/tb_vl_strip_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_vl_strip_ctrl
// Purpose  : Self-checking bench for vl_strip_ctrl with a strip scoreboard.
// Revision : 1.0 - initial release
// =============================================================================
module tb_vl_strip_ctrl;
    localparam int VLEN  = 128;
    localparam int ELEN  = 64;
    localparam int AVL_W = 16;
    localparam int VL_W  = $clog2(VLEN) + 1;

    typedef struct packed {
        logic [31:0] vl;
        logic [31:0] off;
        logic        last;
    } strip_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    strip_t     exp_q[$];
    strip_t     obs_q[$];
    int         obs_k[$];
    logic [63:0] stall_q[$];
    int         exp_csr_vl;
    logic [6:0] exp_vtype;
    int         first_valid_k, done_k, done_cnt, post_abort_valid;
    logic       ready_after_abort;
    bit         timeout;

    int cases [0:8][0:2] = '{'{20, 2, 1}, '{5, 0, 3}, '{0, 2, 1}, '{5, 5, 0}, '{7, 4, 0},
                             '{7, 0, 4}, '{10, 0, 7}, '{33, 1, 2}, '{300, 0, 3}};

    vl_strip_ctrl_if #(.AVL_W(AVL_W), .VL_W(VL_W)) bus ();

    vl_strip_ctrl #(.VLEN(VLEN), .ELEN(ELEN), .AVL_W(AVL_W), .VL_W(VL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: VLMAX = VLEN * LMUL / SEW, filled into the expected queue
    function automatic void model(input int avl, input int vsew, input int vlmul);
        int sew, den, vlmax, rem, off, vl;
        bit legal;
        exp_q.delete();
        legal = 1'b0;
        vlmax = 0;
        if (vsew <= 4) begin
            sew = 8 * (1 << vsew);
            if (vlmul <= 3) begin
                vlmax = (VLEN * (1 << vlmul)) / sew;
                legal = (sew <= ELEN) && (vlmax > 0);
            end
`ifdef VL_STRIP_FRAC_LMUL_EN
            else if (vlmul >= 5) begin
                den   = 1 << (8 - vlmul);
                vlmax = VLEN / (sew * den);
                legal = (sew * den <= ELEN) && (vlmax > 0);
            end
`endif
        end
        exp_vtype  = legal ? {1'b0, 3'(vsew), 3'(vlmul)} : 7'b100_0000;
        exp_csr_vl = legal ? ((avl < vlmax) ? avl : vlmax) : 0;
        rem = legal ? avl : 0;
        off = 0;
        while (rem > 0) begin
            vl = (rem < vlmax) ? rem : vlmax;
            exp_q.push_back('{vl: 32'(vl), off: 32'(off), last: (rem <= vlmax)});
            rem -= vl;
            off += vl;
        end
    endfunction

    task automatic send_req(input int avl, input int vsew, input int vlmul);
        model(avl, vsew, vlmul);
        bus.req_avl   = AVL_W'(avl);
        bus.req_vsew  = 3'(vsew);
        bus.req_vlmul = 3'(vlmul);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Records accepted strips and timing; k counts cycles after the accept edge
    task automatic collect(input int stall_idx, input int stall_len, input int abort_idx);
        int idx, stalls, post;
        bit aborted;
        obs_q.delete(); obs_k.delete(); stall_q.delete();
        first_valid_k = -1; done_k = -1; done_cnt = 0; post_abort_valid = 0;
        ready_after_abort = 1'b0; timeout = 1'b0;
        idx = 0; stalls = 0; post = 0; aborted = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            bus.abort       = 1'b0;
            bus.strip_ready = 1'b1;
            if (aborted) begin
                post++;
                if (bus.strip_valid) post_abort_valid++;
                if (bus.done) done_cnt++;
                if (post == 1) ready_after_abort = bus.req_ready;
                if (post >= 3) break;
            end else begin
                if (bus.done) begin
                    done_cnt++;
                    if (done_k < 0) done_k = k;
                end
                if (bus.strip_valid) begin
                    if (first_valid_k < 0) first_valid_k = k;
                    if (idx == abort_idx) begin
                        bus.abort = 1'b1;
                        aborted   = 1'b1;
                    end else if (idx == stall_idx && stalls < stall_len) begin
                        bus.strip_ready = 1'b0;
                        stalls++;
                        stall_q.push_back({32'(bus.strip_vl), 32'(bus.strip_offset)});
                    end else begin
                        obs_q.push_back('{vl: 32'(bus.strip_vl), off: 32'(bus.strip_offset),
                                          last: bus.strip_last});
                        obs_k.push_back(k);
                        idx++;
                    end
                end
                if (done_k > 0 && k > done_k) break;
            end
            @(negedge clk);
        end
        bus.abort       = 1'b0;
        bus.strip_ready = 1'b1;
        if (!(done_k > 0 || aborted)) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.strip_valid !== 1'b0) begin errors++; $display("FAIL reset_strip_valid got %b want 0", bus.strip_valid); end
        checks++; if (bus.strip_vl !== '0) begin errors++; $display("FAIL reset_strip_vl got %0d want 0", bus.strip_vl); end
        checks++; if (bus.strip_offset !== '0) begin errors++; $display("FAIL reset_strip_offset got %0d want 0", bus.strip_offset); end
        checks++; if (bus.strip_last !== 1'b0) begin errors++; $display("FAIL reset_strip_last got %b want 0", bus.strip_last); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.csr_vl !== '0) begin errors++; $display("FAIL reset_csr_vl got %0d want 0", bus.csr_vl); end
        checks++; if (bus.csr_vtype !== 7'b100_0000) begin errors++; $display("FAIL reset_csr_vtype got %b want 1000000", bus.csr_vtype); end
    endtask

    task automatic test_strips();
        int n_exp, last_k;
        bit gap_ok;
        strip_t e, o;
        for (int c = 0; c < 9; c++) begin
            send_req(cases[c][0], cases[c][1], cases[c][2]);
            collect(-1, 0, -1);
            n_exp  = exp_q.size();
            last_k = (obs_k.size() > 0) ? obs_k[obs_k.size()-1] : -100;
            gap_ok = 1'b1;
            for (int i = 1; i < obs_k.size(); i++) if (obs_k[i] - obs_k[i-1] != 1) gap_ok = 1'b0;
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL case%0d_timeout got no done want done", c); end
            checks++; if (bus.csr_vl !== VL_W'(exp_csr_vl)) begin errors++; $display("FAIL case%0d_csr_vl got %0d want %0d", c, bus.csr_vl, exp_csr_vl); end
            checks++; if (bus.csr_vtype !== exp_vtype) begin errors++; $display("FAIL case%0d_csr_vtype got %b want %b", c, bus.csr_vtype, exp_vtype); end
            checks++; if (obs_q.size() !== n_exp) begin errors++; $display("FAIL case%0d_strip_count got %0d want %0d", c, obs_q.size(), n_exp); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL case%0d_strip got (%0d,%0d,%0d) want (%0d,%0d,%0d)", c, o.vl, o.off, o.last, e.vl, e.off, e.last);
                end
            end
            if (n_exp > 0) begin
                checks++; if (first_valid_k !== 2) begin errors++; $display("FAIL case%0d_first_valid got cycle %0d want 2", c, first_valid_k); end
                checks++; if (done_k !== last_k + 1) begin errors++; $display("FAIL case%0d_done_time got cycle %0d want %0d", c, done_k, last_k + 1); end
                checks++; if (gap_ok !== 1'b1) begin errors++; $display("FAIL case%0d_back_to_back got gaps want none", c); end
            end else begin
                checks++; if (done_k !== 2) begin errors++; $display("FAIL case%0d_done_time got cycle %0d want 2", c, done_k); end
                checks++; if (first_valid_k !== -1) begin errors++; $display("FAIL case%0d_no_strip got valid at %0d want none", c, first_valid_k); end
            end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL case%0d_done_count got %0d want 1", c, done_cnt); end
        end
    endtask

    task automatic test_stall();
        int sum;
        strip_t e, o;
        send_req(24, 2, 1);
        collect(1, 3, -1);
        sum = 0;
        checks++; if (stall_q.size() !== 3) begin errors++; $display("FAIL stall_cycles got %0d want 3", stall_q.size()); end
        foreach (stall_q[i]) begin
            checks++;
            if (stall_q[i] !== {32'd8, 32'd8}) begin
                errors++;
                $display("FAIL stall_hold got (%0d,%0d) want (8,8)", stall_q[i][63:32], stall_q[i][31:0]);
            end
        end
        checks++; if (obs_q.size() !== 3) begin errors++; $display("FAIL stall_strip_count got %0d want 3", obs_q.size()); end
        foreach (obs_q[i]) sum += int'(obs_q[i].vl);
        checks++; if (sum !== 24) begin errors++; $display("FAIL stall_sum got %0d want 24", sum); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_strip got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.vl, o.off, o.last, e.vl, e.off, e.last); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        strip_t e, o;
        send_req(24, 2, 1);
        collect(-1, 0, 1);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL abort_accepted got %0d want 1", obs_q.size()); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", done_cnt); end
        checks++; if (post_abort_valid !== 0) begin errors++; $display("FAIL abort_valid got %0d cycles want 0", post_abort_valid); end
        checks++; if (ready_after_abort !== 1'b1) begin errors++; $display("FAIL abort_req_ready got %b want 1", ready_after_abort); end
        checks++; if (bus.csr_vl !== VL_W'(8)) begin errors++; $display("FAIL abort_csr_vl got %0d want 8", bus.csr_vl); end
        send_req(20, 2, 1);
        collect(-1, 0, -1);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL restart_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL restart_strip got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.vl, o.off, o.last, e.vl, e.off, e.last); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int dcnt;
        send_req(24, 2, 1);
        bus.strip_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.strip_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b want 1", bus.strip_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.strip_ready = 1'b1;
        checks++; if (bus.strip_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.strip_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got %b want 1", bus.req_ready); end
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done) dcnt++;
            @(negedge clk);
        end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL rstmid_done got %0d pulses want 0", dcnt); end
        exp_q.delete();
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_avl     = '0;
        bus.req_vsew    = '0;
        bus.req_vlmul   = '0;
        bus.abort       = 1'b0;
        bus.strip_ready = 1'b1;
        test_reset();
        test_strips();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/vl_strip_ctrl.md
Name: vl_strip_ctrl

Overview:
- Parametrised successor to the combinational vector-length setup logic: a sequential vsetvl plus strip-mining controller.
- Accepts a vector configuration request (AVL, SEW code, LMUL code) and validates it.
- Computes VLMAX from parameter VLEN, registers the vl/vtype CSR values, then issues the AVL as a sequence of strips over a valid/ready handshake to the vector datapath.
- Sits between instruction decode (vsetvl/vsetvli) and the vector lane sequencer.

Parameters:
- VLEN, 128, vector register length in bits; power of two, 64..1024.
- ELEN, 64, maximum legal SEW in bits; power of two, 8..VLEN.
- AVL_W, 16, width of the requested AVL.
- VL_W, $clog2(VLEN)+1, width of vl and strip_vl; holds VLMAX at SEW=8, LMUL=8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  configuration request valid.
- req_ready  out  1  high only in IDLE.
- req_avl  in  AVL_W  application vector length.
- req_vsew  in  3  SEW code: 0=8, 1=16, 2=32, 3=64, 4=128; others reserved.
- req_vlmul  in  3  LMUL code: 0=1, 1=2, 2=4, 3=8; codes 4..7 per Optional Feature.
- abort  in  1  flush in-flight request.
- strip_valid  out  1  strip descriptor valid.
- strip_ready  in  1  downstream accepts strip.
- strip_vl  out  VL_W  elements in this strip.
- strip_offset  out  AVL_W  element index of the strip's first element.
- strip_last  out  1  final strip of the request.
- csr_vl  out  VL_W  architectural vl = min(AVL, VLMAX).
- csr_vtype  out  7  {vill, vsew[2:0], vlmul[2:0]}.
- done  out  1  one-cycle pulse at request completion.

Behaviour:
- Reset (rst=1 at a clock edge) forces state IDLE with outputs: req_ready=1, strip_valid=0, strip_vl=0, strip_offset=0, strip_last=0, done=0, csr_vl=0, csr_vtype=7'b1000000 (vill=1). Reset mid-request discards it with no done pulse.
- Legality: illegal when vsew>4, or SEW>ELEN, or vlmul code unsupported, or VLMAX==0.
- VLMAX = (VLEN >> (3+vsew)) << vlmul, computed at VL_W width with no truncation for legal codes.
- IDLE: req_ready=1. When req_valid is high, latch avl/vsew/vlmul and go to CALC.
- CALC (1 cycle):
  - Compute and register vlmax and legality.
  - Illegal: csr_vl=0, csr_vtype={1,000,000}, go to DONE; no strips issued.
  - Legal: csr_vl=min(avl,vlmax), csr_vtype={0,vsew,vlmul}, remaining=avl, offset=0.
  - avl==0 goes to DONE with no strips.
  - Otherwise go to ISSUE.
- ISSUE:
  - strip_valid=1, strip_vl=min(remaining,vlmax), strip_offset=offset, strip_last=(remaining<=vlmax).
  - Outputs hold stable while strip_ready=0.
  - On strip_valid&&strip_ready: remaining-=strip_vl, offset+=strip_vl. If strip_last, go to DONE; else stay in ISSUE. Back-to-back strips are allowed, one per cycle.
- DONE: done=1 for one cycle, strip_valid=0, go to IDLE.
- Latency: request accepted at cycle N; first strip_valid at N+2; csr_* valid from N+2 and held until the next request's CALC.
- abort: in CALC/ISSUE, go to IDLE next cycle with strip_valid=0 and no done pulse. A strip handshaking in the same cycle as abort counts as not accepted. csr_* keep their last values. abort in IDLE/DONE is ignored (DONE still pulses).
- req_valid outside IDLE is ignored (req_ready=0).
- remaining and offset never wrap: the sum of strip_vl equals avl exactly, and the final offset+strip_vl equals avl.

Optional Feature:
- Macro VL_STRIP_FRAC_LMUL_EN.
- Defined: vlmul codes 5,6,7 = LMUL 1/8, 1/4, 1/2 with VLMAX = (VLEN >> (3+vsew)) >> (8-vlmul). Illegal if VLMAX==0 or SEW > ELEN*LMUL. Code 4 is illegal.
- Not defined: vlmul codes 4..7 are illegal (vill=1).

Test Plan:
- VLEN=128, vsew=2, vlmul=1 (VLMAX=8), avl=20, strip_ready=1 -> strips (vl,off,last) = (8,0,0),(8,8,0),(4,16,1); csr_vl=8; done one cycle after the last strip.
- vsew=0, vlmul=3 (VLMAX=128), avl=5 -> single strip (5,0,1); csr_vl=5; csr_vtype=7'b0000011.
- avl=0, legal config -> no strip_valid, csr_vl=0, done at N+2; vsew=5 -> vill=1, csr_vl=0, no strips, done pulse.
- avl=24, VLMAX=8, strip_ready low for 3 cycles on the second strip -> strip_vl=8 and strip_offset=8 held stable; total of three strips; sum of strip_vl = 24.
- abort asserted while the second of three strips is pending -> IDLE next cycle, no done; a new request is accepted immediately and restarts at offset 0.
- With VL_STRIP_FRAC_LMUL_EN: vsew=0, vlmul=7 (LMUL=1/2), avl=10 -> VLMAX=8, strips (8,0,0),(2,8,1). Without the macro: same request -> vill=1, no strips.
